uart_rx: RTL and testbench
==========================

# uart_rx

Receive control block of the UART peripheral. Oversamples the asynchronous RX pin using the 16x `rx_sample_pulse` from the baud clock generator and deframes start, data, parity and stop bits. Presents each received byte to the UART register block together with `rx_ready`, `parity_err`, `framing_err` and `overflow` status. Sits between the RX pad and `uart_regs`, in parallel with `uart_tx`.

## Interface
- No parameters. Oversample ratio is fixed at 16 (package constant).
- `ACLK` in 1: system clock. Single clock domain.
- `ARESET` in 1: reset. Synchronous, active-high.
- `RX` in 1: serial input. Asynchronous, idle high.
- `rx_sample_pulse` in 1: one-ACLK pulse at 16x the baud rate.
- `data_bits` in 1: word length; 0 = 7 bits, 1 = 8 bits.
- `parity_en` in 1: 1 = parity bit expected after the data bits.
- `parity_odd0_even1` in 1: parity mode; 0 = odd, 1 = even.
- `rx_data_reg_rd` in 1: one-cycle strobe from `uart_regs` when software reads the RX data register.
- `rx_data` out 8: last accepted byte. In 7-bit mode, bit 7 = 0.
- `rx_ready` out 1: unread byte held in `rx_data`.
- `parity_err` out 1: parity mismatch on the byte in `rx_data`.
- `framing_err` out 1: stop bit sampled low on the byte in `rx_data`.
- `overflow` out 1: sticky; a frame completed while `rx_ready` = 1 and was not read in the same cycle.
- `rx_busy` out 1: FSM is not in IDLE.

## Operation
- **Synchronizer:** 2-flop synchronizer on `RX`, both flops reset to 1. All logic uses the synchronized `rxs`.
- **Event timing:** all FSM and counter updates occur only on cycles with `rx_sample_pulse` = 1. `scnt` is a 4-bit sample counter; `bcnt` is a 3-bit bit counter.
- **IDLE:** on a pulse with `rxs` = 0, clear `scnt`, latch `data_bits`, `parity_en` and `parity_odd0_even1` into frame-local copies, and go to START. Register changes mid-frame have no effect until the next frame.
- **START:** at `scnt` = 7 (mid-bit):
  - `rxs` = 1: false start; return to IDLE with no status change.
  - `rxs` = 0: clear `scnt` and `bcnt`, go to DATA.
- **DATA:** at `scnt` = 15, shift `rxs` into the shift register, LSB first. When `bcnt` reaches 6 (7-bit mode) or 7 (8-bit mode), go to PARITY if `parity_en` is set, otherwise to STOP. Otherwise increment `bcnt`.
- **PARITY:** at `scnt` = 15, capture the parity bit and go to STOP.
  - Error in even mode: XOR of data bits and parity bit is 1.
  - Error in odd mode: XOR of data bits and parity bit is 0.
- **STOP:** at `scnt` = 15, sample the stop bit, return to IDLE, and complete the frame. Detection of a new start bit begins on the next pulse.
- **Frame completion, `rx_ready` = 0 or `rx_data_reg_rd` = 1:**
  - load `rx_data`, zero-extended in 7-bit mode;
  - load `parity_err` (0 when parity is disabled);
  - load `framing_err` (1 if the stop bit was 0);
  - set `rx_ready` = 1.
- **Frame completion, `rx_ready` = 1 and no read in the same cycle:**
  - discard the new frame;
  - hold `rx_data`, `parity_err` and `framing_err`;
  - set `overflow` = 1.
- **`rx_data_reg_rd` with no completion in the same cycle:** clear `rx_ready`, `parity_err`, `framing_err` and `overflow`.
- **`rx_data_reg_rd` coinciding with completion:** `rx_ready` stays 1, new data is loaded, and `overflow` is cleared.

## Timing
- **Reset values:**
  - `rx_data` = 0x00;
  - `rx_ready`, `parity_err`, `framing_err`, `overflow`, `rx_busy` = 0;
  - FSM = IDLE, counters = 0, synchronizer = 1.
- **Reset mid-frame:** aborts the frame with no status update.
- **Input latency:** 2 ACLK cycles from `RX` to `rxs`.
- **Output latency:** status outputs update 1 ACLK after the `rx_sample_pulse` that samples the stop bit.
- **Sample points:** start bit at sample 7. Each subsequent bit is sampled 16 pulses later, i.e. mid-bit.
- **Frame duration:** (1 + N + P + 0.5) × 16 `rx_sample_pulse` periods from the start-bit falling edge to completion, where N = data bits and P = 1 if parity is enabled.
- **Registering:** all outputs are registered; no combinational path from `RX` to any output.

## Structure
- **Shared package `uart_pkg`:** holds the FSM state encoding (IDLE, START, DATA, PARITY, STOP; 3-bit), `OVERSAMPLE` = 16, `MID_SAMPLE` = 7 and `LAST_SAMPLE` = 15. The package is shared with `uart_tx` and `baud_clk_gen`.
- **Sub-module `uart_rx_sync`:** 2-flop reset-to-1 synchronizer, reused for any future async inputs.
- **Main body:** FSM, `scnt`, `bcnt`, shift register and status flags, in a single always block per register group.

## Test plan
- **8N1 basic:** bench drives `rx_sample_pulse` every 4 ACLK; send 0xA5 with 8N1 → `rx_ready` = 1, `rx_data` = 0xA5, `parity_err` = 0, `framing_err` = 0. Then pulse `rx_data_reg_rd` → `rx_ready` = 0.
- **7E1 and 7O1:** 7-bit even parity, send 0x35 with correct parity 0 → `rx_data` = 0x35, `parity_err` = 0. Resend with parity bit 1 → `parity_err` = 1. Repeat in odd mode with inverted expectations.
- **False start and framing error:** a 3-sample-wide low glitch on `RX` → no `rx_ready`, `rx_busy` returns to 0. A frame for 0x3C with the stop bit held low → `framing_err` = 1, `rx_data` = 0x3C.
- **Overflow:** send 0x11 then 0x22 without reading → `rx_data` = 0x11, `overflow` = 1. Then a read → all flags cleared. Next, assert `rx_data_reg_rd` on the exact completion cycle of 0x33 → `rx_data` = 0x33, `rx_ready` = 1, `overflow` = 0.
- **Reset mid-frame and config change:** assert `ARESET` during bit 4 of 0xFF → all outputs 0, then a clean 0x5A frame is received correctly. Toggle `data_bits` mid-frame → the current frame uses the latched width.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling constants and the deframer state encoding.
// Used by uart_rx, uart_tx and baud_clk_gen.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int SCNT_W     = $clog2(OVERSAMPLE);

  localparam logic [SCNT_W-1:0] MID_SAMPLE  = SCNT_W'(7);
  localparam logic [SCNT_W-1:0] LAST_SAMPLE = SCNT_W'(15);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Signal bundle between the RX pad / uart_regs side (master) and the uart_rx deframer (slave).
interface uart_rx_if;
  import uart_pkg::*;

  logic        RX;
  logic        rx_sample_pulse;
  logic        data_bits;
  logic        parity_en;
  logic        parity_odd0_even1;
  logic        rx_data_reg_rd;

  // rx_ready = 1 means rx_data holds an unread byte; a one-cycle rx_data_reg_rd
  // consumes it. A frame finishing while unread and unconsumed sets overflow.
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        parity_err;
  logic        framing_err;
  logic        overflow;
  logic        rx_busy;
  uart_state_e dbg_state;

  modport master (
    output RX, rx_sample_pulse, data_bits, parity_en, parity_odd0_even1, rx_data_reg_rd,
    input  rx_data, rx_ready, parity_err, framing_err, overflow, rx_busy, dbg_state
  );

  modport slave (
    input  RX, rx_sample_pulse, data_bits, parity_en, parity_odd0_even1, rx_data_reg_rd,
    output rx_data, rx_ready, parity_err, framing_err, overflow, rx_busy, dbg_state
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous level input; both flops reset to 1
// so an idle-high line never glitches low out of reset.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receive deframer: 16x oversampled start/data/parity/stop decoding with
// byte hand-off status (ready, parity/framing error, sticky overflow).
module uart_rx
  import uart_pkg::*;
(
  input  logic       ACLK,
  input  logic       ARESET,
  uart_rx_if.slave   bus
);

  logic              w_rxs;
  logic              w_pulse;
  uart_state_e       r_state;
  uart_state_e       w_state_next;
  logic [SCNT_W-1:0] r_scnt;
  logic [2:0]        r_bcnt;
  logic [7:0]        r_shift;
  logic              r_cfg_8bit;
  logic              r_cfg_par_en;
  logic              r_cfg_even;
  logic              r_par_bit;
  logic [7:0]        r_rx_data;
  logic              r_rx_ready;
  logic              r_perr;
  logic              r_ferr;
  logic              r_ovf;

  logic w_latch_cfg, w_scnt_clr, w_bcnt_clr, w_bcnt_inc, w_shift_en, w_par_cap, w_complete;
  logic       w_last_bit;
  logic [7:0] w_frame_data;
  logic       w_frame_perr;

  uart_rx_sync u_sync (
    .i_clk   (ACLK),
    .i_rst   (ARESET),
    .i_async (bus.RX),
    .o_sync  (w_rxs)
  );

  assign w_pulse    = bus.rx_sample_pulse;
  assign w_last_bit = (r_bcnt == (r_cfg_8bit ? 3'd7 : 3'd6));

  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_latch_cfg  = 1'b0;
    w_scnt_clr   = 1'b0;
    w_bcnt_clr   = 1'b0;
    w_bcnt_inc   = 1'b0;
    w_shift_en   = 1'b0;
    w_par_cap    = 1'b0;
    w_complete   = 1'b0;
    if (w_pulse) begin
      case (r_state)
        ST_IDLE: if (!w_rxs) begin
          w_latch_cfg  = 1'b1;
          w_scnt_clr   = 1'b1;
          w_state_next = ST_START;
        end
        ST_START: if (r_scnt == MID_SAMPLE) begin
          // A start bit that is high again at mid-bit was only a glitch.
          if (w_rxs) begin
            w_state_next = ST_IDLE;
          end else begin
            w_scnt_clr   = 1'b1;
            w_bcnt_clr   = 1'b1;
            w_state_next = ST_DATA;
          end
        end
        ST_DATA: if (r_scnt == LAST_SAMPLE) begin
          w_shift_en = 1'b1;
          if (w_last_bit) w_state_next = r_cfg_par_en ? ST_PARITY : ST_STOP;
          else            w_bcnt_inc   = 1'b1;
        end
        ST_PARITY: if (r_scnt == LAST_SAMPLE) begin
          w_par_cap    = 1'b1;
          w_state_next = ST_STOP;
        end
        ST_STOP: if (r_scnt == LAST_SAMPLE) begin
          w_complete   = 1'b1;
          w_state_next = ST_IDLE;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET)                           r_scnt <= '0;
    else if (w_pulse && w_scnt_clr)       r_scnt <= '0;
    else if (w_pulse && r_state != ST_IDLE) r_scnt <= r_scnt + 1'b1;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET)          r_bcnt <= 3'd0;
    else if (w_bcnt_clr) r_bcnt <= 3'd0;
    else if (w_bcnt_inc) r_bcnt <= r_bcnt + 3'd1;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_shift   <= 8'h00;
      r_par_bit <= 1'b0;
    end else begin
      if (w_shift_en) r_shift   <= {w_rxs, r_shift[7:1]};
      if (w_par_cap)  r_par_bit <= w_rxs;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_cfg_8bit   <= 1'b1;
      r_cfg_par_en <= 1'b0;
      r_cfg_even   <= 1'b0;
    end else if (w_latch_cfg) begin
      r_cfg_8bit   <= bus.data_bits;
      r_cfg_par_en <= bus.parity_en;
      r_cfg_even   <= bus.parity_odd0_even1;
    end
  end

  // In 7-bit mode the LSB-first shift leaves the word in bits [7:1].
  assign w_frame_data = r_cfg_8bit ? r_shift : {1'b0, r_shift[7:1]};
  assign w_frame_perr = r_cfg_par_en &
                        ((^w_frame_data ^ r_par_bit) ^ ~r_cfg_even);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rx_data  <= 8'h00;
      r_rx_ready <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (w_complete) begin
      if (!r_rx_ready || bus.rx_data_reg_rd) begin
        r_rx_data  <= w_frame_data;
        r_perr     <= w_frame_perr;
        r_ferr     <= ~w_rxs;
        r_rx_ready <= 1'b1;
        if (bus.rx_data_reg_rd) r_ovf <= 1'b0;
      end else begin
        r_ovf <= 1'b1;
      end
    end else if (bus.rx_data_reg_rd) begin
      r_rx_ready <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_ovf      <= 1'b0;
    end
  end

  assign bus.rx_data     = r_rx_data;
  assign bus.rx_ready    = r_rx_ready;
  assign bus.parity_err  = r_perr;
  assign bus.framing_err = r_ferr;
  assign bus.overflow    = r_ovf;
  assign bus.rx_busy     = (r_state != ST_IDLE);
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 64-clock bit period (sample pulse every 4 clocks),
// one task per scenario with inline expected-value checks.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] pcnt = 2'd0;
  int         checks = 0;
  int         errors = 0;

  uart_rx_if bus();

  uart_rx dut (
    .ACLK   (clk),
    .ARESET (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pcnt <= pcnt + 2'd1;
  assign bus.rx_sample_pulse = (pcnt == 2'd3);

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cfg(input logic bits8, input logic pen, input logic even);
    @(negedge clk);
    bus.data_bits         = bits8;
    bus.parity_en         = pen;
    bus.parity_odd0_even1 = even;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic par_en,
                            input logic par_bit, input logic stop_bit);
    @(negedge clk);
    bus.RX = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < nbits; i++) begin
      bus.RX = d[i];
      wait_clks(BIT_CLKS);
    end
    if (par_en) begin
      bus.RX = par_bit;
      wait_clks(BIT_CLKS);
    end
    bus.RX = stop_bit;
    wait_clks(BIT_CLKS);
    bus.RX = 1'b1;
    wait_clks(2 * BIT_CLKS);
  endtask

  task automatic do_read;
    @(negedge clk);
    bus.rx_data_reg_rd = 1'b1;
    @(negedge clk);
    bus.rx_data_reg_rd = 1'b0;
  endtask

  // Raises the read strobe exactly on the cycle whose pulse samples the stop bit.
  task automatic read_on_completion;
    int t = 0;
    int n = 0;
    while (bus.dbg_state !== ST_STOP && t < 3000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 3000) begin
      errors++;
      $display("FAIL stop_state_wait: got state %0d expected %0d within 3000 clocks", bus.dbg_state, ST_STOP);
    end else begin
      while (n < 16) begin
        @(negedge clk);
        if (bus.rx_sample_pulse) n++;
      end
      bus.rx_data_reg_rd = 1'b1;
      @(negedge clk);
      bus.rx_data_reg_rd = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wait_clks(4);
    rst = 1'b0;
    wait_clks(1);
    checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", bus.rx_data); end
    checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.rx_ready); end
    checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", bus.parity_err); end
    checks++; if (bus.framing_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", bus.framing_err); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.overflow); end
    checks++; if (bus.rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.rx_busy); end
  endtask

  task automatic test_8n1;
    set_cfg(1'b1, 1'b0, 1'b0);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL 8n1_ready: got %b expected 1", bus.rx_ready); end
    checks++; if (bus.rx_data !== 8'hA5) begin errors++; $display("FAIL 8n1_data: got %h expected a5", bus.rx_data); end
    checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL 8n1_perr: got %b expected 0", bus.parity_err); end
    checks++; if (bus.framing_err !== 1'b0) begin errors++; $display("FAIL 8n1_ferr: got %b expected 0", bus.framing_err); end
    do_read();
    checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL 8n1_read_clear: got %b expected 0", bus.rx_ready); end
  endtask

  task automatic test_parity;
    // 0x35 as 7 bits has four ones: even parity bit 0, odd parity bit 1.
    set_cfg(1'b0, 1'b1, 1'b1);
    send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1);
    checks++; if (bus.rx_data !== 8'h35) begin errors++; $display("FAIL 7e1_data: got %h expected 35", bus.rx_data); end
    checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL 7e1_good_perr: got %b expected 0", bus.parity_err); end
    do_read();
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1);
    checks++; if (bus.rx_data !== 8'h35) begin errors++; $display("FAIL 7e1_bad_data: got %h expected 35", bus.rx_data); end
    checks++; if (bus.parity_err !== 1'b1) begin errors++; $display("FAIL 7e1_bad_perr: got %b expected 1", bus.parity_err); end
    do_read();
    set_cfg(1'b0, 1'b1, 1'b0);
    send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1);
    checks++; if (bus.rx_data !== 8'h35) begin errors++; $display("FAIL 7o1_bad_data: got %h expected 35", bus.rx_data); end
    checks++; if (bus.parity_err !== 1'b1) begin errors++; $display("FAIL 7o1_bad_perr: got %b expected 1", bus.parity_err); end
    do_read();
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1);
    checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL 7o1_good_perr: got %b expected 0", bus.parity_err); end
    checks++; if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL 7o1_ready: got %b expected 1", bus.rx_ready); end
    do_read();
    checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL parity_read_clear: got %b expected 0", bus.parity_err); end
  endtask

  task automatic test_false_start;
    set_cfg(1'b1, 1'b0, 1'b0);
    bus.RX = 1'b0;
    wait_clks(12);
    bus.RX = 1'b1;
    wait_clks(4);
    checks++; if (bus.rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy: got %b expected 1", bus.rx_busy); end
    wait_clks(100);
    checks++; if (bus.rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %b expected 0", bus.rx_busy); end
    checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL glitch_ready: got %b expected 0", bus.rx_ready); end
  endtask

  task automatic test_framing;
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.framing_err !== 1'b1) begin errors++; $display("FAIL frame_ferr: got %b expected 1", bus.framing_err); end
    checks++; if (bus.rx_data !== 8'h3C) begin errors++; $display("FAIL frame_data: got %h expected 3c", bus.rx_data); end
    checks++; if (bus.rx_busy !== 1'b0) begin errors++; $display("FAIL frame_busy: got %b expected 0", bus.rx_busy); end
    do_read();
    checks++; if (bus.framing_err !== 1'b0) begin errors++; $display("FAIL frame_read_clear: got %b expected 0", bus.framing_err); end
  endtask

  task automatic test_overflow;
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.rx_data !== 8'h11) begin errors++; $display("FAIL ovf_data: got %h expected 11", bus.rx_data); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", bus.overflow); end
    checks++; if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL ovf_ready: got %b expected 1", bus.rx_ready); end
    do_read();
    checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL ovf_read_ready: got %b expected 0", bus.rx_ready); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_read_ovf: got %b expected 0", bus.overflow); end
    send_frame(8'h44, 8, 1'b0, 1'b0, 1'b1);
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set2: got %b expected 1", bus.overflow); end
    fork
      send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1);
      read_on_completion();
    join
    checks++; if (bus.rx_data !== 8'h33) begin errors++; $display("FAIL rdcomp_data: got %h expected 33", bus.rx_data); end
    checks++; if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL rdcomp_ready: got %b expected 1", bus.rx_ready); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rdcomp_ovf: got %b expected 0", bus.overflow); end
  endtask

  task automatic test_reset_mid_frame;
    fork
      send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b1);
      begin
        wait_clks(BIT_CLKS * 5 + 32);
        rst = 1'b1;
        wait_clks(2);
        rst = 1'b0;
      end
    join
    checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h expected 00", bus.rx_data); end
    checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b expected 0", bus.rx_ready); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL midrst_ovf: got %b expected 0", bus.overflow); end
    checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL midrst_perr: got %b expected 0", bus.parity_err); end
    checks++; if (bus.framing_err !== 1'b0) begin errors++; $display("FAIL midrst_ferr: got %b expected 0", bus.framing_err); end
    checks++; if (bus.rx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus.rx_busy); end
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.rx_data !== 8'h5A) begin errors++; $display("FAIL post_rst_data: got %h expected 5a", bus.rx_data); end
    checks++; if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b expected 1", bus.rx_ready); end
    do_read();
  endtask

  task automatic test_config_latch;
    set_cfg(1'b0, 1'b0, 1'b0);
    fork
      send_frame(8'h35, 7, 1'b0, 1'b0, 1'b1);
      begin
        wait_clks(BIT_CLKS * 3);
        bus.data_bits = 1'b1;
      end
    join
    checks++; if (bus.rx_data !== 8'h35) begin errors++; $display("FAIL cfg_latch_data: got %h expected 35", bus.rx_data); end
    checks++; if (bus.framing_err !== 1'b0) begin errors++; $display("FAIL cfg_latch_ferr: got %b expected 0", bus.framing_err); end
    do_read();
  endtask

  initial begin
    bus.RX                = 1'b1;
    bus.rx_data_reg_rd    = 1'b0;
    bus.data_bits         = 1'b1;
    bus.parity_en         = 1'b0;
    bus.parity_odd0_even1 = 1'b0;
    test_reset();
    test_8n1();
    test_parity();
    test_false_start();
    test_framing();
    test_overflow();
    test_reset_mid_frame();
    test_config_latch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
